// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// wb_stage_t is the write-stage record at the core's default widths.
package reg_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREGS      = 32;

  typedef struct packed {
    logic                  en;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_stage_t;

endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer
// moves to the slot after the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               idx;

  // Priority search in rotated order; nothing is granted while in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && !rst && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  // Move the pointer past the winner on a taken grant; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      if (grant_idx == IDX_W'(NUM_REQ - 1)) ptr <= '0;
      else                                  ptr <= grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the register-file write port, with a registered
// write stage and a pending-write scoreboard for RAW stalls in decode.
// Optional macro WB_BYPASS_EN adds same-cycle forwarding of the write stage
// to the two decode source checks.
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [ADDR_W-1:0]         chk_addr_a,
  input  logic [ADDR_W-1:0]         chk_addr_b,
  output logic                      chk_busy_a,
  output logic                      chk_busy_b,
`ifdef WB_BYPASS_EN
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [DATA_W-1:0]         fwd_data_a,
  output logic [DATA_W-1:0]         fwd_data_b,
`endif
  output logic                      rf_write_en,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int SB_BITS = 1 << ADDR_W;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_stage_t;

  logic [IDX_W-1:0]   grant_idx;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  wr_stage_t          wr_q;
  logic [SB_BITS-1:0] sb_q;
  logic [SB_BITS-1:0] sb_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (xfer),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign xfer     = |(req_valid & req_ready);
  assign sel_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

  // Write stage: capture the winner; writes to register 0 never enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
    end else if (xfer) begin
      wr_q.en   <= (sel_addr != '0);
      wr_q.addr <= sel_addr;
      wr_q.data <= sel_data;
    end else begin
      wr_q.en <= 1'b0;
    end
  end

  // Reset drops a write that is sitting in the stage in the same cycle.
  assign rf_write_en   = wr_q.en & ~rst;
  assign rf_write_addr = wr_q.addr;
  assign rf_write_data = wr_q.data;

  // Next scoreboard: retire the current writeback, then a new issue to the
  // same register re-marks it since the newer producer is still in flight.
  always_comb begin
    sb_nxt = sb_q;
    if (rf_write_en) sb_nxt[rf_write_addr] = 1'b0;
    if (issue_valid && issue_addr != '0) sb_nxt[issue_addr] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_nxt;
  end

`ifdef WB_BYPASS_EN
  assign fwd_hit_a  = rf_write_en && (rf_write_addr == chk_addr_a);
  assign fwd_hit_b  = rf_write_en && (rf_write_addr == chk_addr_b);
  assign fwd_data_a = rf_write_data;
  assign fwd_data_b = rf_write_data;
  assign chk_busy_a = sb_q[chk_addr_a] & ~fwd_hit_a;
  assign chk_busy_b = sb_q[chk_addr_b] & ~fwd_hit_b;
`else
  assign chk_busy_a = sb_q[chk_addr_a];
  assign chk_busy_b = sb_q[chk_addr_b];
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter at NUM_REQ=3, DATA_W=32, ADDR_W=5.
module tb_reg_wb_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic             issue_valid;
  logic [AW-1:0]    issue_addr;
  logic [AW-1:0]    chk_addr_a;
  logic [AW-1:0]    chk_addr_b;
  logic             chk_busy_a;
  logic             chk_busy_b;
`ifdef WB_BYPASS_EN
  logic             fwd_hit_a;
  logic             fwd_hit_b;
  logic [DW-1:0]    fwd_data_a;
  logic [DW-1:0]    fwd_data_b;
`endif
  logic             rf_write_en;
  logic [AW-1:0]    rf_write_addr;
  logic [DW-1:0]    rf_write_data;

  int checks = 0;
  int errors = 0;

  reg_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .issue_valid   (issue_valid),
    .issue_addr    (issue_addr),
    .chk_addr_a    (chk_addr_a),
    .chk_addr_b    (chk_addr_b),
    .chk_busy_a    (chk_busy_a),
    .chk_busy_b    (chk_busy_b),
`ifdef WB_BYPASS_EN
    .fwd_hit_a     (fwd_hit_a),
    .fwd_hit_b     (fwd_hit_b),
    .fwd_data_a    (fwd_data_a),
    .fwd_data_b    (fwd_data_b),
`endif
    .rf_write_en   (rf_write_en),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  logic [NR-1:0] rr_grant [6];
  logic [AW-1:0] rr_addr  [6];

  initial begin
    rst = 1'b1; req_valid = '1; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_addr = '0; chk_addr_a = '0; chk_addr_b = '0;
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_en", 64'(rf_write_en), 64'h0);
    chk("rst_addr", 64'(rf_write_addr), 64'h0);
    chk("rst_data", 64'(rf_write_data), 64'h0);
    rst = 1'b0; req_valid = '0;
    #1;
    chk("idle_ready", 64'(req_ready), 64'h0);

    // Single requester
    req_valid = 3'b001; set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("t1_en", 64'(rf_write_en), 64'h1);
    chk("t1_addr", 64'(rf_write_addr), 64'h5);
    chk("t1_data", 64'(rf_write_data), 64'hDEADBEEF);
    tick();
    chk("t1_en_off", 64'(rf_write_en), 64'h0);
    chk("t1_hold_addr", 64'(rf_write_addr), 64'h5);
    chk("t1_hold_data", 64'(rf_write_data), 64'hDEADBEEF);

    // Round-robin: pointer sits at 1 after requester 0 was served.
    set_req(0, 5'd10, 32'h100); set_req(1, 5'd11, 32'h101); set_req(2, 5'd12, 32'h102);
    rr_grant = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    rr_addr  = '{5'd11, 5'd12, 5'd10, 5'd11, 5'd12, 5'd10};
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rr_grant%0d", c), 64'(req_ready), 64'(rr_grant[c]));
      tick();
      chk($sformatf("rr_en%0d", c), 64'(rf_write_en), 64'h1);
      chk($sformatf("rr_addr%0d", c), 64'(rf_write_addr), 64'(rr_addr[c]));
      #1;
    end
    req_valid = '0;
    tick();

    // Register zero: pointer is at 1.
    req_valid = 3'b010; set_req(1, 5'd0, 32'h1);
    issue_valid = 1'b1; issue_addr = 5'd0; chk_addr_a = 5'd0;
    #1;
    chk("z_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0; issue_valid = 1'b0;
    chk("z_en", 64'(rf_write_en), 64'h0);
    chk("z_data", 64'(rf_write_data), 64'h1);
    chk("z_busy", 64'(chk_busy_a), 64'h0);

    // Scoreboard: pointer is at 2.
    issue_valid = 1'b1; issue_addr = 5'd7; chk_addr_a = 5'd7; chk_addr_b = 5'd8;
    #1;
    chk("sb_before", 64'(chk_busy_a), 64'h0);
    tick();
    issue_valid = 1'b0;
    chk("sb_set", 64'(chk_busy_a), 64'h1);
    chk("sb_other", 64'(chk_busy_b), 64'h0);
    req_valid = 3'b100; set_req(2, 5'd7, 32'd77);
    #1;
    chk("sb_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_addr = 5'd7;
    #1;
    chk("sb_wb_en", 64'(rf_write_en), 64'h1);
`ifdef WB_BYPASS_EN
    chk("sb_wb_busy", 64'(chk_busy_a), 64'h0);
    chk("sb_fwd_hit", 64'(fwd_hit_a), 64'h1);
    chk("sb_fwd_data", 64'(fwd_data_a), 64'd77);
`else
    chk("sb_wb_busy", 64'(chk_busy_a), 64'h1);
`endif
    tick();
    issue_valid = 1'b0;
    chk("sb_set_wins", 64'(chk_busy_a), 64'h1);
    req_valid = 3'b001; set_req(0, 5'd7, 32'd78);
    #1;
    chk("sb_ready2", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("sb_en2", 64'(rf_write_en), 64'h1);
    tick();
    chk("sb_clear", 64'(chk_busy_a), 64'h0);

    // Writeback to a clear register keeps it clear; pointer is at 1.
    req_valid = 3'b010; set_req(1, 5'd8, 32'h88);
    tick();
    req_valid = '0;
    chk("sb_clr_en", 64'(rf_write_en), 64'h1);
    tick();
    chk("sb_clr_stay", 64'(chk_busy_b), 64'h0);

`ifdef WB_BYPASS_EN
    // Forwarding on port b; pointer is at 2.
    issue_valid = 1'b1; issue_addr = 5'd9; chk_addr_b = 5'd9;
    tick();
    issue_valid = 1'b0;
    req_valid = 3'b100; set_req(2, 5'd9, 32'd42);
    tick();
    req_valid = '0;
    chk("byp_hit", 64'(fwd_hit_b), 64'h1);
    chk("byp_data", 64'(fwd_data_b), 64'd42);
    chk("byp_busy", 64'(chk_busy_b), 64'h0);
    tick();
    chk("byp_clear", 64'(chk_busy_b), 64'h0);
    chk("byp_hit_off", 64'(fwd_hit_b), 64'h0);
`endif

    // Reset mid-flight: transfer in N with a pending issue, reset in N+1.
    issue_valid = 1'b1; issue_addr = 5'd4; chk_addr_a = 5'd4;
    req_valid = 3'b111; set_req(0, 5'd3, 32'h33); set_req(1, 5'd3, 32'h33); set_req(2, 5'd3, 32'h33);
    #1;
    chk("mr_xfer", 64'(|req_ready), 64'h1);
    tick();
    issue_valid = 1'b0; req_valid = '0;
    rst = 1'b1;
    #1;
    chk("mr_en_n1", 64'(rf_write_en), 64'h0);
    tick();
    rst = 1'b0;
    chk("mr_en_n2", 64'(rf_write_en), 64'h0);
    chk("mr_busy_a", 64'(chk_busy_a), 64'h0);
    chk("mr_busy_b", 64'(chk_busy_b), 64'h0);
    chk("mr_addr", 64'(rf_write_addr), 64'h0);
    req_valid = 3'b111;
    #1;
    chk("mr_ptr0", 64'(req_ready), 64'h1);
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
